// File: rtl/uart_core_if.sv
// Byte-stream side of the UART: TX push handshake, RX pop handshake and per-word RX status.
interface uart_core_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data_in;
  logic                 tx_valid_in;
  logic                 tx_ready_out;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_valid_out;
  logic                 rx_ready_in;
  logic                 rx_parity_err_out;
  logic                 rx_frame_err_out;
  logic                 rx_overrun;

  modport master (
    output tx_data_in, tx_valid_in, rx_ready_in,
    input  tx_ready_out, tx_busy, rx_data_out, rx_valid_out,
           rx_parity_err_out, rx_frame_err_out, rx_overrun
  );
  modport slave (
    input  tx_data_in, tx_valid_in, rx_ready_in,
    output tx_ready_out, tx_busy, rx_data_out, rx_valid_out,
           rx_parity_err_out, rx_frame_err_out, rx_overrun
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART: TX FIFO + framer on txd, synchronised sampler + FWFT RX FIFO on rxd.
// Frames are start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] P1 = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P1;
      if (do_pop)  rd_ptr <= rd_ptr + P1;
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

module uart_core #(
  parameter int DIV        = 868,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  uart_core_if.slave bus,
  output logic       txd,
  input  logic       rxd
);
  localparam int CW = $clog2(DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C1        = 1;
  localparam logic [BW-1:0] B1        = 1;
  localparam logic [CW-1:0] BIT_END   = CW'(DIV - 1);
  localparam logic [CW-1:0] MID       = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam bit PAR_EN  = (PARITY != 0);
  localparam bit PAR_ODD = (PARITY == 1);

  // ---------------- TX ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] txf_dout, tx_shift;
  logic                 txf_empty, txf_full, txf_pop, tx_par, tx_bit_end;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk, .reset,
    .push (bus.tx_valid_in && !txf_full),
    .din  (bus.tx_data_in),
    .pop  (txf_pop),
    .dout (txf_dout),
    .empty(txf_empty),
    .full (txf_full)
  );

  assign tx_bit_end = (tx_cnt == BIT_END);
  // pop from IDLE, or at the very end of the last stop bit for back-to-back frames
  assign txf_pop = !txf_empty &&
                   ((tx_state == TX_IDLE) ||
                    (tx_state == TX_STOP && tx_bit_end && tx_bit == LAST_STOP));
  assign bus.tx_ready_out = !txf_full;
  assign bus.tx_busy      = !txf_empty || (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_cnt <= tx_bit_end ? '0 : tx_cnt + C1;
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (txf_pop) begin
            tx_state <= TX_START;
            txd      <= 1'b0;
            tx_shift <= txf_dout;
            tx_par   <= ^txf_dout ^ PAR_ODD;
          end
        end
        TX_START: if (tx_bit_end) begin
          tx_state <= TX_DATA;
          txd      <= tx_shift[0];
          tx_bit   <= '0;
        end
        TX_DATA: if (tx_bit_end) begin
          tx_shift <= tx_shift >> 1;
          if (tx_bit == LAST_BIT) begin
            tx_bit   <= '0;
            tx_state <= PAR_EN ? TX_PARITY : TX_STOP;
            txd      <= PAR_EN ? tx_par : 1'b1;
          end else begin
            tx_bit <= tx_bit + B1;
            txd    <= tx_shift[1];
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          tx_state <= TX_STOP;
          txd      <= 1'b1;
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_bit == LAST_STOP) begin
            tx_bit <= '0;
            if (txf_pop) begin
              tx_state <= TX_START;
              txd      <= 1'b0;
              tx_shift <= txf_dout;
              tx_par   <= ^txf_dout ^ PAR_ODD;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_bit <= tx_bit + B1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  rx_state_t            rx_state;
  logic [2:0]           rx_pipe;   // [1:0] synchroniser, [2] previous synchronised value
  logic                 rxs, rx_prev, rx_bit_end, rx_perr, rx_push, rx_ovr;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS+1:0] rx_word, rxf_dout;
  logic                 rxf_empty, rxf_full;

  assign rxs        = rx_pipe[1];
  assign rx_prev    = rx_pipe[2];
  assign rx_bit_end = (rx_cnt == BIT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_pipe  <= '1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
      rx_push  <= 1'b0;
      rx_word  <= '0;
    end else begin
      rx_pipe <= {rx_pipe[1:0], rxd};
      rx_push <= 1'b0;
      rx_cnt  <= rx_bit_end ? '0 : rx_cnt + C1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rxs) rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == MID) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_perr  <= 1'b0;
          rx_state <= rxs ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_bit_end) begin
          rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
          rx_bit   <= rx_bit + B1;
          if (rx_bit == LAST_BIT) rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: if (rx_bit_end) begin
          rx_perr  <= ^rx_shift ^ rxs ^ PAR_ODD;
          rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_bit_end) begin
          rx_push  <= 1'b1;
          rx_word  <= {~rxs, rx_perr, rx_shift};
          rx_state <= rxs ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: if (rxs) rx_state <= RX_IDLE;
        default:  rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk, .reset,
    .push (rx_push),
    .din  (rx_word),
    .pop  (bus.rx_ready_in),
    .dout (rxf_dout),
    .empty(rxf_empty),
    .full (rxf_full)
  );

  always_ff @(posedge clk) begin
    if (reset) rx_ovr <= 1'b0;
    else       rx_ovr <= rx_push && rxf_full && !bus.rx_ready_in;
  end

  assign bus.rx_overrun        = rx_ovr;
  assign bus.rx_valid_out      = !rxf_empty;
  assign bus.rx_data_out       = rxf_empty ? '0 : rxf_dout[DATA_BITS-1:0];
  assign bus.rx_parity_err_out = !rxf_empty && rxf_dout[DATA_BITS];
  assign bus.rx_frame_err_out  = !rxf_empty && rxf_dout[DATA_BITS+1];
endmodule
